wave_meas: RTL

Measurement block on the consumer side of the waveform sample stream. It takes 10-bit samples qualified by an enable (the same dout/dout_en interface the DDS generator drives) and measures the stream. On command it counts the samples spanning NCYC full periods, using hysteretic threshold crossings, and tracks peak min/max. Results are presented with a one-cycle done pulse. It sits downstream of the DDS, either in loopback or on an external ADC path, for self-test of frequency word and amplitude settings.

---
 rtl/wave_pkg.sv | 22 ++
 rtl/wave_xdet.sv | 41 ++++
 rtl/wave_meas.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared types and helpers for the waveform measurement block
package wave_pkg;

    localparam int DW_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEAS,
        DONE
    } state_t;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max_v);
        return (a + b > max_v) ? max_v : a + b;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : 32'd0;
    endfunction

endpackage

// File: rtl/wave_xdet.sv
// rtl/wave_xdet.sv - hysteretic threshold crossing detector
module wave_xdet
    import wave_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int HYST = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] din,
    input  logic          din_en,
    input  logic [DW-1:0] thr,
    output logic          level,
    output logic          rise
);
    localparam int unsigned DMAX = 2**DW - 1;

    logic [DW:0] thr_hi;
    logic [DW:0] thr_lo;
    logic [DW:0] din_x;
    logic        fall;

    // One extra bit so the saturated bounds compare cleanly against the sample
    assign din_x  = {1'b0, din};
    assign thr_hi = (DW+1)'(sat_add(32'(thr), HYST, DMAX));
    assign thr_lo = (DW+1)'(sat_sub(32'(thr), HYST));

    assign rise = din_en && !level && (din_x >= thr_hi);
    assign fall = din_en && level && (din_x <= thr_lo);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level <= 1'b0;
        end else if (rise) begin
            level <= 1'b1;
        end else if (fall) begin
            level <= 1'b0;
        end
    end

endmodule

// File: rtl/wave_meas.sv
// rtl/wave_meas.sv - period and peak measurement over NCYC periods of a sample stream
module wave_meas
    import wave_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NCYC  = 4,
    parameter int CNT_W = 16,
    parameter int HYST  = 8,
    parameter int TMO   = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DW-1:0]    din,
    input  logic             din_en,
    input  logic [DW-1:0]    thr,
    input  logic             meas_start,
    output logic             meas_busy,
    output logic             meas_done,
    output logic [CNT_W-1:0] period_cnt,
    output logic [DW-1:0]    vmax,
    output logic [DW-1:0]    vmin,
    output logic             timeout
);
    localparam int               EW        = $clog2(NCYC + 1);
    localparam logic [EW-1:0]    LAST_EDGE = EW'(NCYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO - 1);

    state_t           state;
    state_t           next_state;
    logic             rise;
    logic             xdet_level_unused;
    logic             armed;
    logic             tmo_hit;
    logic             tmo_term;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [EW-1:0]    edge_cnt;
    logic [DW-1:0]    cur_min;
    logic [DW-1:0]    cur_max;

    wave_xdet #(.DW(DW), .HYST(HYST)) u_xdet (
        .clk    (clk),
        .rstn   (rstn),
        .din    (din),
        .din_en (din_en),
        .thr    (thr),
        .level  (xdet_level_unused),
        .rise   (rise)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A rising event on the timeout sample wins over the timeout
    always_comb begin
        next_state = state;
        tmo_term   = 1'b0;
        meas_busy  = (state == SYNC) || (state == MEAS);
        meas_done  = (state == DONE);
        tmo_hit    = din_en && !rise && (tmo_cnt == TMO_LAST);
        case (state)
            IDLE: begin
                if (meas_start && armed) next_state = SYNC;
            end
            SYNC: begin
                if (rise) begin
                    next_state = MEAS;
                end else if (tmo_hit) begin
                    next_state = DONE;
                    tmo_term   = 1'b1;
                end
            end
            MEAS: begin
                if (rise && (edge_cnt == LAST_EDGE)) begin
                    next_state = DONE;
                end else if (tmo_hit) begin
                    next_state = DONE;
                    tmo_term   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed      <= 1'b0;
            sample_cnt <= '0;
            tmo_cnt    <= '0;
            edge_cnt   <= '0;
            cur_min    <= '0;
            cur_max    <= '0;
            period_cnt <= '0;
            vmax       <= '0;
            vmin       <= '0;
            timeout    <= 1'b0;
        end else begin
            // Keeps a start pulse coincident with reset release from being taken
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    tmo_cnt  <= '0;
                    edge_cnt <= '0;
                    if (next_state == SYNC) begin
                        sample_cnt <= '0;
                        cur_min    <= '0;
                        cur_max    <= '0;
                    end
                end
                SYNC: begin
                    if (din_en) begin
                        if (rise) begin
                            sample_cnt <= CNT_W'(1);
                            cur_min    <= din;
                            cur_max    <= din;
                            edge_cnt   <= '0;
                            tmo_cnt    <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                MEAS: begin
                    if (din_en && (next_state == MEAS)) begin
                        if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
                        if (din < cur_min) cur_min <= din;
                        if (din > cur_max) cur_max <= din;
                        if (rise) begin
                            edge_cnt <= edge_cnt + 1'b1;
                            tmo_cnt  <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if ((state != DONE) && (next_state == DONE)) begin
                timeout    <= tmo_term;
                period_cnt <= tmo_term ? '0 : sample_cnt;
                vmax       <= cur_max;
                vmin       <= cur_min;
            end
        end
    end

endmodule
